// File: rtl/acc_pkg.sv
// acc_pkg: shared definitions for the accumulator CPU control path.
//   - opcode encodings (IR[9:6])
//   - ALU operation select encodings
//   - control FSM state encoding (also exported on the debug state port)
package acc_pkg;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_LDA = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_STA = 4'b0101;
  localparam logic [3:0] OP_CLA = 4'b0110;
  localparam logic [3:0] OP_JMP = 4'b0111;
  localparam logic [3:0] OP_JZ  = 4'b1000;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;
  localparam logic [1:0] ALU_AND  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_OPRD   = 3'd3,
    S_EXEC   = 3'd4,
    S_STORE  = 3'd5,
    S_HALT   = 3'd6
  } state_t;

endpackage

// File: rtl/acc_wdog.sv
// acc_wdog: memory-access watchdog for the accumulator control FSM.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : restart the wait count (FSM is changing state)
//   waiting    : FSM is in a memory-access state and mem_ready is low
//   expire     : this wait cycle is the TIMEOUT-th one (combinational)
//   bus_err    : sticky fault flag, cleared only by reset
// TIMEOUT = 0 disables the watchdog entirely.
module acc_wdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic waiting,
  output logic expire,
  output logic bus_err
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  // cnt holds the number of wait cycles already seen; the cycle that finds
  // LIMIT already counted is the TIMEOUT-th wait cycle.
  localparam logic [CW-1:0] LIMIT = (TIMEOUT < 1) ? '0 : CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  assign expire = (TIMEOUT != 0) && waiting && (cnt == LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      bus_err <= 1'b0;
    end else begin
      if (clear)
        cnt <= '0;
      else if (waiting && (cnt != LIMIT))
        cnt <= cnt + 1'b1;
      if (expire)
        bus_err <= 1'b1;
    end
  end

endmodule

// File: rtl/acc_ctrl.sv
// acc_ctrl: multicycle control FSM for the 10-bit accumulator CPU.
// Sequences fetch, decode, operand read, execute and store.
//   clk, rst_n  : clock, asynchronous active-low reset
//   run         : 1 = execute; 0 = stop at the next instruction boundary
//   opcode      : IR[9:6], valid from the cycle after ir_load
//   ac_zero     : accumulator is zero (for JZ)
//   mem_ready   : current memory access completes this cycle
//   mem_rd/mem_wr, addr_sel (0 PC, 1 IR[5:0]), ir_load, mdr_load,
//   pc_inc, pc_load, ac_re, ac_clear, alu_op : datapath controls
//   halted      : FSM in HALT
//   bus_err     : sticky watchdog fault
//   state       : current state (debug)
module acc_ctrl
  import acc_pkg::*;
#(
  parameter int OPW     = 4,
  parameter int TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           run,
  input  logic [OPW-1:0] opcode,
  input  logic           ac_zero,
  input  logic           mem_ready,
  output logic           mem_rd,
  output logic           mem_wr,
  output logic           addr_sel,
  output logic           ir_load,
  output logic           mdr_load,
  output logic           pc_inc,
  output logic           pc_load,
  output logic           ac_re,
  output logic           ac_clear,
  output logic [1:0]     alu_op,
  output logic           halted,
  output logic           bus_err,
  output logic [2:0]     state
);

  state_t state_q, state_d, next_insn;
  logic   waiting, expire;

  // Instruction boundary: run is only looked at here.
  assign next_insn = run ? S_FETCH : S_IDLE;

  assign waiting = ((state_q == S_FETCH) || (state_q == S_OPRD) ||
                    (state_q == S_STORE)) && !mem_ready;

  // Any state change (including a timeout into HALT) restarts the count,
  // which covers entry into every memory-access state.
  acc_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state_d != state_q),
    .waiting (waiting),
    .expire  (expire),
    .bus_err (bus_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    addr_sel = 1'b0;
    ir_load  = 1'b0;
    mdr_load = 1'b0;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    ac_re    = 1'b0;
    ac_clear = 1'b0;
    alu_op   = ALU_PASS;
    halted   = 1'b0;
    case (state_q)
      S_IDLE: if (run) state_d = S_FETCH;
      S_FETCH: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          ir_load = 1'b1;
          pc_inc  = 1'b1;
          state_d = S_DECODE;
        end else if (expire) begin
          state_d = S_HALT;
        end
      end
      S_DECODE: begin
        case (opcode)
          OPW'(OP_LDA), OPW'(OP_ADD),
          OPW'(OP_SUB), OPW'(OP_AND): state_d = S_OPRD;
          OPW'(OP_STA):               state_d = S_STORE;
          OPW'(OP_CLA): begin
            ac_clear = 1'b1;
            state_d  = next_insn;
          end
          OPW'(OP_JMP): begin
            pc_load = 1'b1;
            state_d = next_insn;
          end
          OPW'(OP_JZ): begin
            pc_load = ac_zero;
            state_d = next_insn;
          end
          OPW'(OP_HLT):               state_d = S_HALT;
          default:                    state_d = next_insn;
        endcase
      end
      S_OPRD: begin
        mem_rd   = 1'b1;
        addr_sel = 1'b1;
        if (mem_ready) begin
          mdr_load = 1'b1;
          state_d  = S_EXEC;
        end else if (expire) begin
          state_d = S_HALT;
        end
      end
      S_EXEC: begin
        ac_re = 1'b1;
        case (opcode)
          OPW'(OP_ADD): alu_op = ALU_ADD;
          OPW'(OP_SUB): alu_op = ALU_SUB;
          OPW'(OP_AND): alu_op = ALU_AND;
          default:      alu_op = ALU_PASS;
        endcase
        state_d = next_insn;
      end
      S_STORE: begin
        mem_wr   = 1'b1;
        addr_sel = 1'b1;
        if (mem_ready)   state_d = next_insn;
        else if (expire) state_d = S_HALT;
      end
      S_HALT: begin
        halted = 1'b1;
        // Leaving HALT goes through IDLE, so a restart needs run 0 -> 1.
        if (!run) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign state = state_q;

endmodule

// File: doc/acc_ctrl.md
Name: acc_ctrl

Overview:
- Multicycle control FSM for the 10-bit accumulator CPU.
- Sequences instruction fetch, decode, operand read, execute and store.
- Drives the accumulator (load/clear), PC, IR, MDR, ALU-op and memory strobes, with a ready handshake to memory.
- Sits between the IR opcode field and the datapath registers; one instance per core.

Parameters:
- OPW, 4, opcode width (IR[9:6]).
- TIMEOUT, 15, max cycles a memory access may wait for mem_ready before fault; 0 disables the watchdog.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- run  in  1  level; 1 = execute, 0 = stop at the next instruction boundary
- opcode  in  OPW  IR[9:6]; stable from the cycle after ir_load
- ac_zero  in  1  accumulator == 0
- mem_ready  in  1  current mem_rd/mem_wr completes this cycle; read data valid this cycle
- mem_rd  out  1  memory read strobe
- mem_wr  out  1  memory write strobe (data = AC)
- addr_sel  out  1  0 = PC, 1 = IR[5:0]
- ir_load  out  1  IR <= mem data
- mdr_load  out  1  MDR <= mem data
- pc_inc  out  1  PC <= PC+1
- pc_load  out  1  PC <= IR[5:0]
- ac_re  out  1  AC <= ALU result (accumulator load enable)
- ac_clear  out  1  AC <= 0
- alu_op  out  2  00 pass MDR, 01 AC+MDR, 10 AC-MDR, 11 AC&MDR
- halted  out  1  1 in HALT
- bus_err  out  1  sticky watchdog fault
- state  out  3  current state (debug)

Behaviour:
- Opcodes: 0000 NOP, 0001 LDA, 0010 ADD, 0011 SUB, 0100 AND, 0101 STA, 0110 CLA, 0111 JMP, 1000 JZ, 1111 HLT; all others decode as NOP.
- Reset (async, rst_n=0): state=IDLE, wait counter=0, bus_err=0. All outputs 0 while in reset and in IDLE.
- Output timing: outputs are combinational from state (plus opcode, mem_ready, ac_zero where listed). At most one of mem_rd/mem_wr is high; at most one of ac_re/ac_clear is high.
- "NEXT" below means: go to FETCH if run=1, else IDLE. An instruction in progress always completes; run is sampled only at this boundary.
- IDLE: run=1 -> FETCH.
- FETCH: mem_rd=1, addr_sel=0.
  - mem_ready=1: ir_load=1, pc_inc=1 (same cycle); go to DECODE.
  - mem_ready=0: stay.
- DECODE (1 cycle, opcode valid):
  - LDA/ADD/SUB/AND -> OPRD.
  - STA -> STORE.
  - CLA: ac_clear=1; NEXT.
  - JMP: pc_load=1; NEXT.
  - JZ: pc_load=ac_zero; NEXT.
  - HLT -> HALT.
  - NOP: NEXT.
- OPRD: mem_rd=1, addr_sel=1. mem_ready=1: mdr_load=1, go to EXEC; else stay.
- EXEC (1 cycle): ac_re=1, alu_op from opcode (LDA 00, ADD 01, SUB 10, AND 11); NEXT. alu_op=00 in all other states.
- STORE: mem_wr=1, addr_sel=1. mem_ready=1 -> NEXT; else stay.
- HALT: halted=1. run=0 -> IDLE; run=1 -> stay. Restart needs a 0->1 on run; PC is not touched.
- Watchdog: counter clears on entry to FETCH/OPRD/STORE and increments each cycle mem_ready=0 in those states.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT: set bus_err, go to HALT, drop strobes.
  - bus_err clears only on reset.
  - mem_ready on the same cycle as the limit wins: normal transition, no fault.
- Latency with zero-wait memory:
  - CLA/JMP/JZ/NOP: 2 cycles.
  - STA: 3 cycles.
  - LDA/ADD/SUB/AND: 4 cycles.
- Reset mid-access: strobes drop asynchronously and the FSM restarts in IDLE.

Decomposition:
- Package acc_pkg:
  - opcode constants (OP_NOP..OP_HLT)
  - alu_op constants
  - state encoding: IDLE 0, FETCH 1, DECODE 2, OPRD 3, EXEC 4, STORE 5, HALT 6
- Sub-module acc_wdog: the TIMEOUT wait counter plus sticky bus_err, with inputs clear/waiting.
- FSM and decode remain in acc_ctrl.

Test Plan:
- Reset with run=1, mem_ready=1, then release -> IDLE for 1 cycle; FETCH next (mem_rd=1, ir_load=1, pc_inc=1); all outputs 0 during reset.
- LDA (0001), zero-wait memory -> cycles FETCH, DECODE, OPRD (mdr_load=1, addr_sel=1), EXEC (ac_re=1, alu_op=00); FETCH on cycle 5.
- STA with mem_ready held low 3 cycles -> mem_wr=1 for 4 cycles, addr_sel=1 throughout, ac_re never asserted.
- JZ with ac_zero=1 -> pc_load=1 in DECODE. Repeat with ac_zero=0 -> pc_load=0; both return to FETCH.
- run dropped during OPRD of ADD -> EXEC still asserts ac_re with alu_op=01, then IDLE.
- HLT -> halted=1 and stays with run=1; run=0 gives IDLE, run=1 gives FETCH.
- TIMEOUT=4, mem_ready=0 in FETCH -> bus_err=1 and HALT after 4 wait cycles; mem_rd=0 from then on. rst_n low clears bus_err.
